// File: rtl/if_stage_pkg.sv
// Shared constants for the fetch stage: reset PC, bubble word, instruction field
// positions, the opcode/funct values the decoder uses, and redirect-target helpers.
package if_stage_pkg;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

  localparam int OP_MSB     = 31;
  localparam int OP_LSB     = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_MSB = 25;
  localparam int TARGET_LSB = 0;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_JR   = 6'h08;

  typedef enum logic [1:0] {
    SEL_PC4    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_JR     = 2'd3
  } pc_sel_e;

  // Branch base is the delay-slot address; offset is the word-scaled immediate.
  function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                input logic [15:0] imm);
    return pc4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [25:0] tgt);
    return {pc4[31:28], tgt, 2'b00};
  endfunction

  // Misaligned register targets are silently word-aligned rather than trapped.
  function automatic logic [31:0] jr_align(input logic [31:0] rs_val);
    return rs_val & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_next_pc.sv
// Next-PC selection: qualifies the decoder's redirect request and picks the
// target with jr > jump > branch priority, falling back to pc+4.
module if_next_pc
  import if_stage_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] id_instr_i,
  input  logic [31:0] id_pc4_i,
  input  logic        id_valid_i,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic        jr_i,
  input  logic        br_taken_i,
  input  logic [31:0] jr_target_i,
  output logic        redir_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] next_pc_o
);

  pc_sel_e     sel;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] jr_tgt;
  logic        unused_op_bits;

  assign unused_op_bits = ^id_instr_i[OP_MSB:OP_LSB];

  assign pc_plus4_o = pc_i + 32'd4;
  assign br_tgt     = branch_target(id_pc4_i, id_instr_i[IMM_MSB:IMM_LSB]);
  assign j_tgt      = jump_target(id_pc4_i, id_instr_i[TARGET_MSB:TARGET_LSB]);
  assign jr_tgt     = jr_align(jr_target_i);

  // A bubble in ID carries stale decode, so it must never steer the PC.
  assign redir_o = id_valid_i & ~stall_i & (jr_i | jump_i | br_taken_i);

  always_comb begin
    sel = SEL_PC4;
    if (redir_o) begin
      if (jr_i)          sel = SEL_JR;
      else if (jump_i)   sel = SEL_JUMP;
      else               sel = SEL_BRANCH;
    end
  end

  always_comb begin
    next_pc_o = pc_plus4_o;
    case (sel)
      SEL_JR:     next_pc_o = jr_tgt;
      SEL_JUMP:   next_pc_o = j_tgt;
      SEL_BRANCH: next_pc_o = br_tgt;
      default:    next_pc_o = pc_plus4_o;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, combinational imem address, and the
// IF/ID pipeline register with stall hold and redirect squash/delay-slot handling.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = PC_RESET_DEF,
  parameter logic [31:0] NOP_WORD   = NOP_WORD_DEF,
  parameter bit          DELAY_SLOT = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        jump,
  input  logic        jr,
  input  logic        br_taken,
  input  logic [31:0] jr_target,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic [5:0]  id_op,
  output logic [5:0]  id_funct
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        id_valid_q, id_valid_d;

  logic        redir;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  if_next_pc u_next_pc (
    .pc_i        (pc_q),
    .id_instr_i  (id_instr_q),
    .id_pc4_i    (id_pc4_q),
    .id_valid_i  (id_valid_q),
    .stall_i     (stall),
    .jump_i      (jump),
    .jr_i        (jr),
    .br_taken_i  (br_taken),
    .jr_target_i (jr_target),
    .redir_o     (redir),
    .pc_plus4_o  (pc_plus4),
    .next_pc_o   (next_pc)
  );

  always_comb begin
    pc_d       = pc_q;
    id_instr_d = id_instr_q;
    id_pc4_d   = id_pc4_q;
    id_valid_d = id_valid_q;
    if (!stall) begin
      pc_d     = next_pc;
      id_pc4_d = pc_plus4;
      // Without a delay slot the word fetched behind a taken redirect is dropped.
      if (redir && !DELAY_SLOT) begin
        id_instr_d = NOP_WORD;
        id_valid_d = 1'b0;
      end else begin
        id_instr_d = imem_rdata;
        id_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q       <= PC_RESET;
      id_instr_q <= NOP_WORD;
      id_pc4_q   <= 32'd0;
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc4_q   <= id_pc4_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign imem_addr = pc_q;
  assign id_instr  = id_instr_q;
  assign id_pc4    = id_pc4_q;
  assign id_valid  = id_valid_q;
  assign id_op     = id_instr_q[OP_MSB:OP_LSB];
  assign id_funct  = id_instr_q[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: one instance without and one with a delay slot,
// driven by a small combinational instruction-memory model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rstn0, rstn1;
  logic        stall, jump, jr, br_taken;
  logic [31:0] jr_target;

  logic [31:0] imem_addr0, imem_rdata0, id_instr0, id_pc40;
  logic        id_valid0;
  logic [5:0]  id_op0, id_funct0;
  logic [31:0] imem_addr1, imem_rdata1, id_instr1, id_pc41;
  logic        id_valid1;
  logic [5:0]  id_op1, id_funct1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_3000: return 32'h2008_0005;  // addi $t0,$0,5
      32'h0000_3008: return 32'h0800_0C10;  // j 0x3040
      32'h0000_3040: return 32'h1000_FFFE;  // beq $0,$0,-2
      default:       return 32'h2400_0000 | {16'h0000, a[15:0]};
    endcase
  endfunction

  assign imem_rdata0 = mem_word(imem_addr0);
  assign imem_rdata1 = mem_word(imem_addr1);

  if_stage #(.DELAY_SLOT(1'b0)) dut0 (
    .clk(clk), .rstn(rstn0), .imem_addr(imem_addr0), .imem_rdata(imem_rdata0),
    .stall(stall), .jump(jump), .jr(jr), .br_taken(br_taken), .jr_target(jr_target),
    .id_instr(id_instr0), .id_pc4(id_pc40), .id_valid(id_valid0),
    .id_op(id_op0), .id_funct(id_funct0)
  );

  if_stage #(.DELAY_SLOT(1'b1)) dut1 (
    .clk(clk), .rstn(rstn1), .imem_addr(imem_addr1), .imem_rdata(imem_rdata1),
    .stall(stall), .jump(jump), .jr(jr), .br_taken(br_taken), .jr_target(jr_target),
    .id_instr(id_instr1), .id_pc4(id_pc41), .id_valid(id_valid1),
    .id_op(id_op1), .id_funct(id_funct1)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("  ok %s = %h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn0 = 1'b0; rstn1 = 1'b0;
    stall = 1'b0; jump = 1'b0; jr = 1'b0; br_taken = 1'b0;
    jr_target = 32'h0;
    step(); step();

    check_val("rst_addr",  imem_addr0, 32'h0000_3000);
    check_val("rst_instr", id_instr0,  32'h0000_0000);
    check_val("rst_pc4",   id_pc40,    32'h0000_0000);
    check_val("rst_valid", {31'b0, id_valid0}, 32'd0);

    rstn0 = 1'b1;
    step();
    check_val("f1_instr", id_instr0, 32'h2008_0005);
    check_val("f1_pc4",   id_pc40,   32'h0000_3004);
    check_val("f1_valid", {31'b0, id_valid0}, 32'd1);
    check_val("f1_addr",  imem_addr0, 32'h0000_3004);
    check_val("f1_op",    {26'b0, id_op0},    32'h08);
    check_val("f1_funct", {26'b0, id_funct0}, 32'h05);

    step();
    check_val("f2_addr",  imem_addr0, 32'h0000_3008);
    check_val("f2_instr", id_instr0,  32'h2400_3004);

    stall = 1'b1;
    step();
    check_val("st1_addr",  imem_addr0, 32'h0000_3008);
    check_val("st1_instr", id_instr0,  32'h2400_3004);
    step();
    check_val("st2_addr",  imem_addr0, 32'h0000_3008);
    check_val("st2_instr", id_instr0,  32'h2400_3004);
    stall = 1'b0;
    step();
    check_val("res_addr",  imem_addr0, 32'h0000_300C);
    check_val("res_instr", id_instr0,  32'h0800_0C10);
    check_val("res_pc4",   id_pc40,    32'h0000_300C);

    jump = 1'b1;
    step();
    check_val("j_addr",  imem_addr0, 32'h0000_3040);
    check_val("j_instr", id_instr0,  32'h0000_0000);
    check_val("j_valid", {31'b0, id_valid0}, 32'd0);

    // jump still high from stale decode: the bubble must not redirect
    step();
    check_val("stale_addr",  imem_addr0, 32'h0000_3044);
    check_val("stale_valid", {31'b0, id_valid0}, 32'd1);
    check_val("stale_instr", id_instr0, 32'h1000_FFFE);
    check_val("stale_pc4",   id_pc40,   32'h0000_3044);

    jump = 1'b0; br_taken = 1'b1; stall = 1'b1;
    step();
    check_val("brst_addr",  imem_addr0, 32'h0000_3044);
    check_val("brst_instr", id_instr0,  32'h1000_FFFE);
    stall = 1'b0;
    step();
    check_val("br_addr",  imem_addr0, 32'h0000_303C);
    check_val("br_valid", {31'b0, id_valid0}, 32'd0);

    br_taken = 1'b0;
    step();
    check_val("nb_addr",  imem_addr0, 32'h0000_3040);
    check_val("nb_valid", {31'b0, id_valid0}, 32'd1);
    check_val("nb_pc4",   id_pc40,    32'h0000_3040);

    jr = 1'b1; jump = 1'b1; br_taken = 1'b1; jr_target = 32'h0000_3103;
    step();
    check_val("prio_addr", imem_addr0, 32'h0000_3100);
    jr = 1'b0; jump = 1'b0; br_taken = 1'b0;
    step();
    check_val("post_addr", imem_addr0, 32'h0000_3104);

    jr = 1'b1; jr_target = 32'hFFFF_FFFE;
    step();
    check_val("top_addr", imem_addr0, 32'hFFFF_FFFC);
    jr = 1'b0;
    step();
    check_val("wrap_addr",  imem_addr0, 32'h0000_0000);
    check_val("wrap_pc4",   id_pc40,    32'h0000_0000);
    check_val("wrap_instr", id_instr0,  32'h2400_FFFC);

    jump = 1'b1; rstn0 = 1'b0;
    step();
    check_val("rr_addr",  imem_addr0, 32'h0000_3000);
    check_val("rr_valid", {31'b0, id_valid0}, 32'd0);
    check_val("rr_instr", id_instr0, 32'h0000_0000);
    jump = 1'b0;

    // Delay-slot instance
    rstn1 = 1'b1;
    step(); step(); step();
    check_val("ds_addr",  imem_addr1, 32'h0000_300C);
    check_val("ds_instr", id_instr1,  32'h0800_0C10);
    jump = 1'b1;
    step();
    check_val("dsj_addr",  imem_addr1, 32'h0000_3040);
    check_val("dsj_instr", id_instr1,  32'h2400_300C);
    check_val("dsj_valid", {31'b0, id_valid1}, 32'd1);
    check_val("dsj_pc4",   id_pc41,    32'h0000_3010);
    jump = 1'b0;
    step();
    check_val("dsn_instr", id_instr1, 32'h1000_FFFE);
    br_taken = 1'b1;
    step();
    check_val("dsb_addr",  imem_addr1, 32'h0000_303C);
    check_val("dsb_instr", id_instr1,  32'h2400_3044);
    check_val("dsb_valid", {31'b0, id_valid1}, 32'd1);
    br_taken = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC, drives the instruction-memory address, and loads the IF/ID pipeline register.
- Feeds Op/Funct to the ID-stage control decoder.
- Consumes the decoder's redirect outputs (Jump, Jal, Jr, Branch/bne resolution) plus the hazard unit's stall, so it is the producing and redirect-consuming end of the decoder interface.

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded at reset; first fetch address.
- NOP_WORD, 32'h0000_0000, instruction word written into IF/ID on a bubble (sll $0,$0,0).
- DELAY_SLOT, 0, 0 = squash the instruction fetched behind a taken redirect; 1 = keep it (MIPS delay slot).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rstn  in  1  synchronous reset, active low.
- imem_addr  out  32  instruction-memory byte address (= pc); memory read is combinational.
- imem_rdata  in  32  instruction word at imem_addr, same cycle.
- stall  in  1  hazard unit: hold PC and IF/ID (load-use).
- jump  in  1  decoder Jump OR Jal for the instruction in ID.
- jr  in  1  decoder Jr for the instruction in ID.
- br_taken  in  1  Branch & (eq XOR bne), resolved in ID.
- jr_target  in  32  forwarded rs value for jr.
- id_instr  out  32  IF/ID instruction register.
- id_pc4  out  32  IF/ID PC+4 (jal link value, branch base).
- id_valid  out  1  IF/ID holds a real instruction, not a bubble.
- id_op  out  6  id_instr[31:26] to decoder Op.
- id_funct  out  6  id_instr[5:0] to decoder Funct.

Behaviour:
- Reset is synchronous, active low: pc=PC_RESET, id_instr=NOP_WORD, id_pc4=0, id_valid=0.
- imem_addr = pc combinationally, including during reset (pc=PC_RESET).
- Redirect is qualified: redir = id_valid & ~stall & (jr | jump | br_taken).
- Target priority is jr > jump > br_taken; more than one set is a decoder fault, resolved by this priority.
  - jr: {jr_target[31:2],2'b00}. Low bits are forced to zero; no exception is raised.
  - jump: {id_pc4[31:28], id_instr[25:0], 2'b00}.
  - branch: id_pc4 + ({{14{id_instr[15]}}, id_instr[15:0], 2'b00}), 32-bit wrap-around.
- Per clock (rstn=1), in priority order:
  1. stall=1: pc, id_instr, id_pc4, id_valid all hold. Redirect inputs are ignored.
  2. redir=1, DELAY_SLOT=0: pc<=target; id_instr<=NOP_WORD; id_valid<=0; id_pc4<=pc+4 (don't-care).
  3. redir=1, DELAY_SLOT=1: pc<=target; id_instr<=imem_rdata; id_pc4<=pc+4; id_valid<=1.
  4. Otherwise: pc<=pc+4 (wraps at 2^32); id_instr<=imem_rdata; id_pc4<=pc+4; id_valid<=1.
- Latency: fetch at cycle n is visible on id_* at cycle n+1. Redirect penalty is 1 bubble with DELAY_SLOT=0, 0 with DELAY_SLOT=1.
- A bubble (id_valid=0) never redirects, even if jump/jr/br_taken are asserted from stale decode.
- Reset asserted mid-stall or mid-redirect overrides everything on that edge.
- id_op/id_funct are pure slices of id_instr. A bubble decodes as R-type sll (harmless, writes $0).

Decomposition:
- Shared package/include: PC_RESET value, NOP_WORD, and the instruction field bit positions (OP [31:26], FUNCT [5:0], IMM [15:0], TARGET [25:0]) next to the existing opcode/funct defines.
- One sub-module is natural: if_next_pc. It is combinational: priority mux of pc+4 / branch / jump / jr targets, and produces redir.
- The top block holds the PC register and the IF/ID register.

Test Plan:
- Reset then release, memory returns 32'h2008_0005 at 0x3000 → cycle 1: id_instr=32'h2008_0005, id_pc4=0x3004, id_valid=1, pc=0x3004; id_op=6'h08.
- Straight-line 4 fetches, stall held 2 cycles at the third → pc holds 0x3008 for 2 cycles, id_instr unchanged, then resumes 0x300C.
- id_instr=j with target 26'h0000C10, id_pc4=0x3008, jump=1 → next pc=0x0000_3040, id_valid=0, id_instr=0 (DELAY_SLOT=0); repeat with DELAY_SLOT=1 → id_instr=word at 0x3008, id_valid=1.
- beq in ID with imm=16'hFFFE, id_pc4=0x3010, br_taken=1 → pc=0x3008. Same case with stall=1 → pc holds, no redirect.
- jr=1, jump=1, br_taken=1 together, jr_target=0x0000_3103 → pc=0x0000_3100 (jr wins, low bits cleared).
- Assert rstn=0 during a redirect cycle → pc=0x3000, id_valid=0. Separately, pc=32'hFFFF_FFFC with no redirect → pc wraps to 0.
